fsize_quantizer: RTL and testbench
==================================

# fsize_quantizer

Streaming float-to-integer quantizer, the inverse direction of `fsize_multiplier`. It accepts `FLOAT_SIZE` floating-point values, scales each by a power of two, rounds to nearest-even and saturates. It emits `INT_SIZE`-bit two's-complement codes for the SPARQ integer datapath. It is a 3-stage elastic pipeline with AXI-stream valid/ready on both sides, throughput one beat per cycle, and an optional saturation event counter.

## Interface
- Package constants `FLOAT_SIZE`, `EXP_SIZE`, `MANT_SIZE`, `BIAS`, `INT_SIZE` come from `SPARQ_PKG` (reference build: 16/5/10/15/4).
- `SAT_CNT_W`, default 16: width of the saturation counter.
- `aclk`  in  1: clock; all state changes on its rising edge.
- `areset`  in  1: asynchronous, active-high reset.
- `s_axis_a_tvalid`  in  1: input beat valid.
- `s_axis_a_tready`  out  1: input beat accepted when both valid and ready are high on an edge.
- `s_axis_a_tdata`  in  `FLOAT_SIZE`: float value, laid out as {sign, exp, mant}.
- `scale_shift`  in  6, signed: power-of-two scale applied to the beat. It is sampled together with the beat at acceptance.
- `m_axis_result_tvalid`  out  1: output beat valid.
- `m_axis_result_tready`  in  1: downstream ready.
- `m_axis_result_tdata`  out  `INT_SIZE`: two's-complement result code.
- `sat_count`  out  `SAT_CNT_W`: number of saturated output beats.

## Operation
- Exact semantics: q = sat(rne(x · 2^scale_shift)). Saturation range is [−2^(INT_SIZE−1), 2^(INT_SIZE−1)−1], i.e. [−8, 7].
- Decode of `exp`:
  - `exp != 0`: frac = {1, mant}, e = exp − BIAS.
  - `exp == 0`: frac = {0, mant}, e = 1 − BIAS.
  - The value is frac · 2^(e − MANT_SIZE + scale_shift).
- Shift handling, with E = e − MANT_SIZE + scale_shift:
  - E ≥ 0 with frac ≠ 0: left shift. If E ≥ INT_SIZE, the magnitude overflows and saturates with no shift performed.
  - E < 0: right shift by R = −E, keeping guard bit G, round bit Rb and sticky bit S.
  - R ≥ MANT_SIZE+2: the magnitude is below 0.5 and the result is 0.
- Rounding is round-half-to-even on the magnitude: increment if G & (Rb | S | lsb).
- Sign is applied after rounding.
- Saturation:
  - Positive magnitude > 7 gives 7.
  - Negative magnitude > 8 gives −8.
  - Negative magnitude exactly 8 gives −8 and does NOT count as saturation.
- Special inputs (exp all ones):
  - NaN (mant ≠ 0) gives 0 and is not counted.
  - +Inf gives 7 and is counted.
  - −Inf gives −8 and is counted.
- ±0 and any result rounding to zero give code 0. There is no −0 code.
- Pipeline stages:
  - S1: decode plus shift-amount computation.
  - S2: shift, round bits and overflow flag.
  - S3: round, sign, saturate; this is the output register.
- Each stage has a valid bit. A stage loads when it is empty or its downstream stage advances.
- `s_axis_a_tready` = !S1.valid | S1 advances. It is combinational from `m_axis_result_tready`, with no bubble at full throughput.
- Output stability: while `m_axis_result_tvalid` && !`m_axis_result_tready`, `m_axis_result_tdata` and tvalid hold stable.

## Timing
- A beat accepted on edge N enters S1 at N, S2 at N+1 and S3 at N+2. `m_axis_result_tvalid` is high in the cycle after edge N+2.
- Latency is 3 edges with no backpressure.
- Sustained throughput is 1 beat/cycle while `m_axis_result_tready` is held high.
- Backpressure fills S3, then S2, then S1, then `s_axis_a_tready` drops. No beat is lost or duplicated, and order is preserved.
- Reset values:
  - `m_axis_result_tvalid` = 0, `m_axis_result_tdata` = 0, `sat_count` = 0.
  - All stage valid bits are 0.
  - `s_axis_a_tready` = 0 while `areset` is high and 1 from the first cycle after release.
- Reset mid-operation drops all in-flight beats immediately (asynchronously). No partial output is produced.
- `sat_count` increments on the output handshake edge of a saturated beat. It holds at all-ones and does not wrap.
- When an input accept and an output handshake occur on the same edge, both take effect.

## Configuration
- `SPARQ_QUANT_SATCNT_EN` defined: the saturation counter is built and behaves as above.
- `SPARQ_QUANT_SATCNT_EN` undefined:
  - No counter or saturation-flag pipeline bits are built.
  - `sat_count` is tied to 0.
  - The datapath and timing are otherwise identical.

## Test plan
- Basic rounding, `scale_shift`=0, expected results:
  - 0x3C00 → 0x1.
  - 0x4100 (2.5) → 0x2.
  - 0x4300 (3.5) → 0x4.
  - 0xBE00 (−1.5) → 0xE.
  - All appear 3 edges after acceptance.
- Scaling: 0x3600 (0.375) with shift +3 → 0x3; 0x4A00 (12.0) with shift −2 → 0x3; 0x0001 (min subnormal) with shift 0 → 0x0.
- Saturation with `SPARQ_QUANT_SATCNT_EN`:
  - Inputs 0x5640 (100.0), 0xC800 (−8.0), 0xC880 (−9.0), 0x7C00, 0xFC00, 0x7E00.
  - Expected outputs 0x7, 0x8, 0x8, 0x7, 0x8, 0x0.
  - `sat_count` ends at 4.
- Backpressure: stream 16 beats back-to-back while `m_axis_result_tready` toggles pseudo-randomly. Require all 16 results in order, and tdata stable while stalled. `s_axis_a_tready` must be low only when S1–S3 are full and the output is stalled.
- Reset mid-stream: assert `areset` with 3 beats in flight. Outputs and `sat_count` must go to 0 immediately, and no stale beat may appear after release. The next accepted beat must have latency 3.
- Counter ceiling: with `SAT_CNT_W`=2, send 5 saturating beats; `sat_count` must stick at 3. With the macro undefined, `sat_count` must stay at 0.

Source files
------------

// File: rtl/fsize_quantizer.sv
// fsize_quantizer: streaming float -> INT_SIZE-bit integer quantizer.
// q = sat(rne(x * 2^scale_shift)), 3-stage elastic pipeline with
// valid/ready on both sides and one beat per cycle throughput.
// Optional feature macro: SPARQ_QUANT_SATCNT_EN builds the saturation
// event counter; without it sat_count is tied to zero.

package SPARQ_PKG;
    parameter int FLOAT_SIZE = 16;
    parameter int EXP_SIZE   = 5;
    parameter int MANT_SIZE  = 10;
    parameter int BIAS       = 15;
    parameter int INT_SIZE   = 4;
endpackage

module fsize_quantizer
    import SPARQ_PKG::*;
#(
    parameter int SAT_CNT_W = 16
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  s_axis_a_tvalid,
    output logic                  s_axis_a_tready,
    input  logic [FLOAT_SIZE-1:0] s_axis_a_tdata,
    input  logic signed [5:0]     scale_shift,
    output logic                  m_axis_result_tvalid,
    input  logic                  m_axis_result_tready,
    output logic [INT_SIZE-1:0]   m_axis_result_tdata,
    output logic [SAT_CNT_W-1:0]  sat_count
);
    localparam int STAGES = 3;
    localparam int FRAC_W = MANT_SIZE + 1;
    localparam int MAG_W  = FRAC_W + INT_SIZE;   // widest left-shifted magnitude
    localparam int LOW_W  = MANT_SIZE + 2;       // shifted-out room for G, Rb, sticky
    localparam int EXT_W  = FRAC_W + LOW_W;
    localparam int SH_W   = 8;                   // covers e - MANT_SIZE + scale_shift
    localparam logic [INT_SIZE-1:0] Q_MAX = {1'b0, {(INT_SIZE-1){1'b1}}};
    localparam logic [INT_SIZE-1:0] Q_MIN = {1'b1, {(INT_SIZE-1){1'b0}}};
    localparam logic [MAG_W-1:0] MAG_POS = MAG_W'(2**(INT_SIZE-1) - 1);
    localparam logic [MAG_W-1:0] MAG_NEG = MAG_W'(2**(INT_SIZE-1));

    logic [STAGES:1] vld_pipe;
    logic            load1, load2, load3;

    // stage 1 decode
    logic                 d_sign;
    logic [EXP_SIZE-1:0]  d_exp;
    logic [MANT_SIZE-1:0] d_mant;
    logic [SH_W-1:0]      d_e, d_shift;

    logic                 s1_sign, s1_nan, s1_inf;
    logic [FRAC_W-1:0]    s1_frac;
    logic [SH_W-1:0]      s1_shift;

    // stage 2 shift
    logic                 ovf_d, g_d, rb_d, st_d;
    logic [MAG_W-1:0]     mag_d;
    logic [SH_W-1:0]      rsh;
    logic [EXT_W-1:0]     ext;

    logic                 s2_sign, s2_ovf, s2_g, s2_rb, s2_st;
    logic [MAG_W-1:0]     s2_mag;

    // stage 3 round / saturate
    logic [MAG_W-1:0]     rnd;
    logic [INT_SIZE-1:0]  q_d, q;

    // A stage loads when empty or when its downstream stage moves on.
    always_comb begin
        load3 = !vld_pipe[3] || m_axis_result_tready;
        load2 = !vld_pipe[2] || load3;
        load1 = !vld_pipe[1] || load2;
    end

    assign s_axis_a_tready      = load1 && !areset;
    assign m_axis_result_tvalid = vld_pipe[3];
    assign m_axis_result_tdata  = q;

    // Stage valid bits; reset drops every in-flight beat at once.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            vld_pipe <= '0;
        end else begin
            if (load1) vld_pipe[1] <= s_axis_a_tvalid;
            if (load2) vld_pipe[2] <= vld_pipe[1];
            if (load3) vld_pipe[3] <= vld_pipe[2];
        end
    end

    assign d_sign = s_axis_a_tdata[FLOAT_SIZE-1];
    assign d_exp  = s_axis_a_tdata[FLOAT_SIZE-2 -: EXP_SIZE];
    assign d_mant = s_axis_a_tdata[MANT_SIZE-1:0];

    // Unbiased exponent and total binary-point shift E (two's complement).
    always_comb begin
        d_e     = (d_exp == '0) ? SH_W'(1 - BIAS) : SH_W'(d_exp) - SH_W'(BIAS);
        d_shift = d_e - SH_W'(MANT_SIZE) + {{(SH_W-6){scale_shift[5]}}, scale_shift};
    end

    // Stage 1 register: sign, significand, shift and special-value class.
    always_ff @(posedge aclk) begin
        if (load1 && s_axis_a_tvalid) begin
            s1_sign  <= d_sign;
            s1_frac  <= {|d_exp, d_mant};
            s1_shift <= d_shift;
            s1_nan   <= (&d_exp) && (|d_mant);
            s1_inf   <= (&d_exp) && !(|d_mant);
        end
    end

    // Align the significand: left shift or overflow for E >= 0, right
    // shift with guard/round/sticky capture for E < 0.
    always_comb begin
        ovf_d = 1'b0;
        mag_d = '0;
        g_d   = 1'b0;
        rb_d  = 1'b0;
        st_d  = 1'b0;
        rsh   = '0;
        ext   = '0;
        if (!s1_nan && s1_frac != '0) begin
            if (s1_inf) begin
                ovf_d = 1'b1;
            end else if (!s1_shift[SH_W-1]) begin
                if (s1_shift >= SH_W'(INT_SIZE)) ovf_d = 1'b1;
                else                             mag_d = MAG_W'(s1_frac) << s1_shift;
            end else begin
                rsh = -s1_shift;
                // Shifts of MANT_SIZE+2 or more leave a value below 0.5.
                if (rsh < SH_W'(LOW_W)) begin
                    ext   = {s1_frac, {LOW_W{1'b0}}} >> rsh;
                    mag_d = MAG_W'(ext[EXT_W-1:LOW_W]);
                    g_d   = ext[LOW_W-1];
                    rb_d  = ext[LOW_W-2];
                    st_d  = |ext[LOW_W-3:0];
                end
            end
        end
    end

    // Stage 2 register: magnitude, rounding bits and overflow flag.
    always_ff @(posedge aclk) begin
        if (load2 && vld_pipe[1]) begin
            s2_sign <= s1_sign;
            s2_mag  <= mag_d;
            s2_g    <= g_d;
            s2_rb   <= rb_d;
            s2_st   <= st_d;
            s2_ovf  <= ovf_d;
        end
    end

    // Round half to even on the magnitude, then apply sign and clamp.
    always_comb begin
        rnd = s2_mag + MAG_W'(s2_g && (s2_rb || s2_st || s2_mag[0]));
        q_d = '0;
        if (s2_ovf)       q_d = s2_sign ? Q_MIN : Q_MAX;
        else if (!s2_sign) q_d = (rnd > MAG_POS) ? Q_MAX : rnd[INT_SIZE-1:0];
        else               q_d = (rnd > MAG_NEG) ? Q_MIN : -rnd[INT_SIZE-1:0];
    end

    // Output register; holds while the downstream stalls.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset)                  q <= '0;
        else if (load3 && vld_pipe[2]) q <= q_d;
    end

`ifdef SPARQ_QUANT_SATCNT_EN
    logic                 sat_d, s3_sat;
    logic [SAT_CNT_W-1:0] sat_cnt;

    // Clamped beats count; -2^(INT_SIZE-1) exactly is representable.
    always_comb begin
        sat_d = s2_ovf || (rnd > (s2_sign ? MAG_NEG : MAG_POS));
    end

    // Saturation flag travels with the beat in the output stage.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset)                  s3_sat <= 1'b0;
        else if (load3 && vld_pipe[2]) s3_sat <= sat_d;
    end

    // Count on the output handshake, sticking at all-ones.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset)
            sat_cnt <= '0;
        else if (vld_pipe[3] && m_axis_result_tready && s3_sat && !(&sat_cnt))
            sat_cnt <= sat_cnt + SAT_CNT_W'(1);
    end

    assign sat_count = sat_cnt;
`else
    assign sat_count = '0;
`endif

endmodule

// File: tb/tb_fsize_quantizer.sv
// Testbench for fsize_quantizer: directed vectors, random streams under
// backpressure, mid-stream reset and saturation-counter ceiling, checked
// against a real-arithmetic reference model and an in-order scoreboard.
module tb_fsize_quantizer;
`ifdef SPARQ_QUANT_SATCNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              s_valid, s_ready, s_ready2;
    logic [15:0]       s_data;
    logic signed [5:0] s_ss;
    logic              m_valid, m_valid2, m_ready;
    logic [3:0]        m_data, m_data2;
    logic [15:0]       sat_count;
    logic [1:0]        sat_count2;

    int          n_assert = 0;
    int          n_fail   = 0;
    int          sat_n    = 0;
    logic [4:0]  exp_q[$];
    bit          stall_prev = 0;
    logic [3:0]  prev_data  = '0;

    always #5 clk = ~clk;

    fsize_quantizer #(.SAT_CNT_W(16)) dut (
        .aclk(clk), .areset(rst),
        .s_axis_a_tvalid(s_valid), .s_axis_a_tready(s_ready),
        .s_axis_a_tdata(s_data), .scale_shift(s_ss),
        .m_axis_result_tvalid(m_valid), .m_axis_result_tready(m_ready),
        .m_axis_result_tdata(m_data), .sat_count(sat_count)
    );

    fsize_quantizer #(.SAT_CNT_W(2)) dut2 (
        .aclk(clk), .areset(rst),
        .s_axis_a_tvalid(s_valid), .s_axis_a_tready(s_ready2),
        .s_axis_a_tdata(s_data), .scale_shift(s_ss),
        .m_axis_result_tvalid(m_valid2), .m_axis_result_tready(m_ready),
        .m_axis_result_tdata(m_data2), .sat_count(sat_count2)
    );

    // Reference: exact value as a real, round half even, clamp. Returns {sat, code}.
    function automatic logic [4:0] model(input logic [15:0] f, input int ss);
        int  ex, mt, frac, e;
        real mag, p, r, d;
        bit  odd;
        ex = int'(f[14:10]);
        mt = int'(f[9:0]);
        if (ex == 31) begin
            if (mt != 0) return 5'h00;
            return f[15] ? 5'h18 : 5'h17;
        end
        frac = (ex == 0) ? mt : mt + 1024;
        e    = (ex == 0) ? -14 : ex - 15;
        p = 1.0;
        for (int k = 0; k < e - 10 + ss; k++) p = p * 2.0;
        for (int k = 0; k > e - 10 + ss; k--) p = p / 2.0;
        mag = real'(frac) * p;
        r   = $floor(mag);
        d   = mag - r;
        odd = ($floor(r / 2.0) * 2.0) != r;
        if (d > 0.5 || (d == 0.5 && odd)) r = r + 1.0;
        if (!f[15]) return (r > 7.0) ? 5'h17 : {1'b0, 4'($rtoi(r))};
        if (r > 8.0) return 5'h18;
        return {1'b0, 4'(-$rtoi(r))};
    endfunction

    function automatic int exp_cnt(input int n, input int cap);
        if (!CNT_EN) return 0;
        return (n > cap) ? cap : n;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One clock with inputs set at the preceding negedge.
    task automatic tick(output bit acc);
        logic [4:0] e;
        bit         of, pend;
        #1;
        acc  = s_valid && s_ready;
        of   = m_valid && m_ready;
        pend = 0;
        check("s_ready", s_ready, !rst && !(exp_q.size() == 3 && !m_ready));
        check("s_ready_w2", s_ready2, !rst && !(exp_q.size() == 3 && !m_ready));
        if (stall_prev) begin
            check("hold_valid", m_valid, 1);
            check("hold_data", m_data, prev_data);
        end
        if (of) begin
            if (exp_q.size() == 0) begin
                check("spurious_valid", m_valid, 0);
            end else begin
                e = exp_q.pop_front();
                check("data", m_data, e[3:0]);
                check("data_w2", m_data2, e[3:0]);
                check("valid_w2", m_valid2, 1);
                pend = e[4];
            end
        end
        if (acc) exp_q.push_back(model(s_data, int'(s_ss)));
        stall_prev = m_valid && !m_ready;
        prev_data  = m_data;
        @(posedge clk);
        @(negedge clk);
        if (pend) sat_n++;
        check("sat_count", sat_count, exp_cnt(sat_n, 65535));
        check("sat_count_w2", sat_count2, exp_cnt(sat_n, 3));
    endtask

    // Single beat into an empty pipe: accept, then result exactly 3 edges later.
    task automatic send_one(input logic [15:0] f, input logic signed [5:0] ss, input logic [3:0] q);
        bit a;
        s_valid = 1; s_data = f; s_ss = ss; m_ready = 1;
        tick(a);
        check("accept", a, 1);
        s_valid = 0;
        check("lat_e1", m_valid, 0);
        tick(a);
        check("lat_e2", m_valid, 0);
        tick(a);
        check("lat_e3", m_valid, 1);
        check("result", m_data, q);
        tick(a);
    endtask

    task automatic gen(output logic [15:0] f, output logic signed [5:0] ss);
        f = 16'($urandom);
        if ($urandom_range(0, 3) == 0) ss = 6'($urandom);
        else ss = 6'(15 - int'(f[14:10]) + int'($urandom_range(0, 6)) - 2);
    endtask

    task automatic drain(input bit rnd_ready);
        bit a;
        s_valid = 0;
        for (int c = 0; c < 100 && exp_q.size() > 0; c++) begin
            m_ready = rnd_ready ? 1'($urandom) : 1'b1;
            tick(a);
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        bit a;
        int sent;
        logic [15:0] f;
        logic signed [5:0] ss;

        rst = 1; s_valid = 1; s_data = 16'h3C00; s_ss = 0; m_ready = 1;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_valid", m_valid, 0);
        check("rst_data", m_data, 0);
        check("rst_sat", sat_count, 0);
        check("rst_ready", s_ready, 0);
        @(negedge clk);
        rst = 0; s_valid = 0;
        tick(a);

        // rounding and scaling
        send_one(16'h3C00, 0, 4'h1);
        send_one(16'h4100, 0, 4'h2);
        send_one(16'h4300, 0, 4'h4);
        send_one(16'hBE00, 0, 4'hE);
        send_one(16'h3600, 3, 4'h3);
        send_one(16'h4A00, -2, 4'h3);
        send_one(16'h0001, 0, 4'h0);

        // saturation and specials
        send_one(16'h5640, 0, 4'h7);
        send_one(16'hC800, 0, 4'h8);
        send_one(16'hC880, 0, 4'h8);
        send_one(16'h7C00, 0, 4'h7);
        send_one(16'hFC00, 0, 4'h8);
        send_one(16'h7E00, 0, 4'h0);
        check("sat_after_specials", sat_count, CNT_EN ? 4 : 0);

        // 16 back-to-back beats with random downstream ready
        sent = 0;
        gen(f, ss);
        s_valid = 1; s_data = f; s_ss = ss;
        for (int c = 0; c < 400 && sent < 16; c++) begin
            m_ready = 1'($urandom);
            tick(a);
            if (a) begin
                sent++;
                gen(f, ss);
                s_data = f; s_ss = ss;
                s_valid = (sent < 16);
            end
        end
        check("stream_sent", sent, 16);
        drain(1);

        // random valid and ready
        s_valid = 0;
        for (int c = 0; c < 300; c++) begin
            if (!s_valid || a) begin
                gen(f, ss);
                s_data = f; s_ss = ss;
                s_valid = 1'($urandom);
            end
            m_ready = ($urandom_range(0, 9) < 7);
            tick(a);
        end
        drain(1);

        // reset with three beats in flight
        m_ready = 0; s_valid = 1;
        for (int k = 0; k < 3; k++) begin
            s_data = 16'h7C00 ^ 16'(k); s_ss = 0;
            tick(a);
            check("fill_accept", a, 1);
        end
        check("pre_rst_valid", m_valid, 1);
        #2 rst = 1;
        #1;
        check("mid_rst_valid", m_valid, 0);
        check("mid_rst_data", m_data, 0);
        check("mid_rst_sat", sat_count, 0);
        check("mid_rst_ready", s_ready, 0);
        exp_q.delete();
        sat_n = 0;
        stall_prev = 0;
        @(negedge clk);
        rst = 0; s_valid = 0; m_ready = 1;
        for (int k = 0; k < 4; k++) begin
            tick(a);
            check("post_rst_idle", m_valid, 0);
        end
        send_one(16'h4300, 0, 4'h4);

        // counter ceiling: five saturating beats
        s_valid = 1; s_data = 16'h7C00; s_ss = 0; m_ready = 1;
        sent = 0;
        for (int c = 0; c < 20 && sent < 5; c++) begin
            s_data = (sent % 2 == 1) ? 16'hFC00 : 16'h5640;
            tick(a);
            if (a) sent++;
            s_valid = (sent < 5);
        end
        drain(0);
        check("ceil_w2", sat_count2, CNT_EN ? 3 : 0);
        check("cnt_after_ceiling", sat_count, CNT_EN ? 5 : 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
